hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage core. It drives the stop/flush inputs of the PC,
//  IF/ID, ID/EX and EX/MEM pipeline registers, and the ID-stage operand-forwarding selects.
//  It resolves load-use stalls, taken-branch squashes and multi-cycle data-memory waits.
//  A watchdog halts the pipeline if memory never completes. Stall/flush statistics are counted.
// PARAMETERS
//  TIMEOUT    256   max consecutive mem_busy cycles before entering ERR (>=2)
//  CNT_W      16    width of saturating performance counters
//  WESL_LOAD  2'b01 rf_wesl encoding meaning "write-back from DRAM" (load)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  id_rs1       in   5      ID source register 1
//  id_rs2       in   5      ID source register 2
//  id_re1       in   1      ID actually reads rs1
//  id_re2       in   1      ID actually reads rs2
//  ex_wr        in   5      EX destination register
//  ex_we        in   1      EX register write enable
//  ex_rf_wesl   in   2      EX write-back source select
//  mem_wr       in   5      MEM destination register
//  mem_we       in   1      MEM register write enable
//  wb_wr        in   5      WB destination register
//  wb_we        in   1      WB register write enable
//  ex_br_taken  in   1      branch/jump in EX resolved taken (redirect happens this cycle)
//  mem_busy     in   1      data memory not ready; the access in MEM must be held
//  pc_stop      out  1      hold PC
//  if_id_stop   out  1      hold IF/ID
//  if_id_flush  out  1      clear IF/ID
//  id_ex_stop   out  1      hold ID/EX
//  id_ex_flush  out  1      clear ID/EX (bubble)
//  ex_mem_stop  out  1      hold EX/MEM
//  fwd_a        out  2      rs1 operand source: 0 RF, 1 EX result, 2 MEM, 3 WB
//  fwd_b        out  2      rs2 operand source (same encoding)
//  err          out  1      sticky watchdog error
//  stall_cnt    out  CNT_W  cycles with pc_stop=1 (saturating)
//  flush_cnt    out  CNT_W  cycles with if_id_flush=1 (saturating)
// BEHAVIOUR
//  - Reset: FSM=RUN, wait counter=0, err=0, counters=0. While rst_n=0 every stop/flush/fwd output is 0.
//  - Outputs are combinational from FSM state and the current inputs. State and counters update on the posedge clk.
//  - FSM RUN: mem_busy=1 -> WAIT (wait cnt=1); otherwise stay in RUN.
//  - FSM WAIT: mem_busy=0 -> RUN (wait cnt=0); mem_busy=1 and wait cnt==TIMEOUT-1 -> ERR; otherwise wait cnt++.
//  - FSM ERR: absorbing until reset; err=1; all four stops=1, both flushes=0.
//  - Priority per cycle is freeze > branch > load-use:
//    freeze (mem_busy=1 in RUN/WAIT): all four stops=1, flushes=0; ex_br_taken is ignored because the
//     branch stays frozen in EX;
//    branch (ex_br_taken=1): if_id_flush=1, id_ex_flush=1, all stops=0;
//    load-use (ex_we & ex_rf_wesl==WESL_LOAD & ex_wr!=0 & (id_re1&rs1==ex_wr | id_re2&rs2==ex_wr)):
//     pc_stop=1, if_id_stop=1, id_ex_flush=1, ex_mem_stop=0. The stall lasts exactly 1 cycle, because the
//     bubble clears ex_we.
//  - Forwarding for each source with re=1 and rs!=0 selects the youngest match: EX(1, non-load only) >
//    MEM(2) > WB(3) > RF(0). If re=0 or rs=0, the select is 0. A load in EX is never forwarded from EX.
//  - Forwarding selects are valid in every state. Consumers sample them only when id_ex_stop=0.
//  - Counters saturate at all-ones and never wrap. They also increment in ERR.
//  - Asynchronous reset mid-WAIT/ERR returns to RUN immediately; outputs go to 0 with no clock needed.
// TESTING
//  - lw x5 in EX, ID add reads x5 -> one cycle pc_stop=if_id_stop=id_ex_flush=1, then fwd_a=2 with no stop.
//  - ex_br_taken=1 together with a load-use hazard -> if_id_flush=id_ex_flush=1, pc_stop=0, flush_cnt+1.
//  - mem_busy high 3 cycles with ex_br_taken=1 -> 3 cycles all stops=1, no flush; then a 1-cycle flush.
//  - TIMEOUT=4, mem_busy held high -> err=1 after 4 busy cycles; stops stay 1; rst_n low clears all.
//  - x0 written in EX/MEM/WB, ID reads x0 -> fwd_a=fwd_b=0, no stall.
//  - rs1 matches both MEM and WB -> fwd_a=2. The same case with re1=0 -> fwd_a=0.
//  - stall_cnt driven past 2^CNT_W-1 -> holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: stalls, squashes, memory-wait freeze, forwarding
// Watchdog FSM freezes the pipe on mem_busy and latches err if memory never completes.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned CNT_W     = 16,
  parameter logic [1:0]  WESL_LOAD = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_wr,
  input  logic             ex_we,
  input  logic [1:0]       ex_rf_wesl,
  input  logic [4:0]       mem_wr,
  input  logic             mem_we,
  input  logic [4:0]       wb_wr,
  input  logic             wb_we,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             pc_stop,
  output logic             if_id_stop,
  output logic             if_id_flush,
  output logic             id_ex_stop,
  output logic             id_ex_flush,
  output logic             ex_mem_stop,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WC_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WC_W-1:0]   r_wait_cnt;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_halt;
  logic w_freeze;
  logic w_ex_load;
  logic w_ex_fwd_ok;
  logic w_load_use;

  assign w_halt      = (r_state == S_ERR);
  assign w_freeze    = mem_busy && !w_halt;
  assign w_ex_load   = ex_we && (ex_rf_wesl == WESL_LOAD);
  // A load result is not available until MEM, so EX never forwards a load.
  assign w_ex_fwd_ok = ex_we && !w_ex_load;
  assign w_load_use  = w_ex_load && (ex_wr != 5'd0) &&
                       ((id_re1 && (id_rs1 == ex_wr)) || (id_re2 && (id_rs2 == ex_wr)));

  function automatic logic [1:0] fwd_sel(
    input logic       re,
    input logic [4:0] rs,
    input logic       ex_ok,
    input logic [4:0] exw,
    input logic       mem_ok,
    input logic [4:0] memw,
    input logic       wb_ok,
    input logic [4:0] wbw
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (re && (rs != 5'd0)) begin
      if (ex_ok && (exw == rs))        sel = 2'd1;
      else if (mem_ok && (memw == rs)) sel = 2'd2;
      else if (wb_ok && (wbw == rs))   sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    pc_stop     = 1'b0;
    if_id_stop  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stop  = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_stop = 1'b0;
    fwd_a       = 2'd0;
    fwd_b       = 2'd0;
    if (rst_n) begin
      fwd_a = fwd_sel(id_re1, id_rs1, w_ex_fwd_ok, ex_wr, mem_we, mem_wr, wb_we, wb_wr);
      fwd_b = fwd_sel(id_re2, id_rs2, w_ex_fwd_ok, ex_wr, mem_we, mem_wr, wb_we, wb_wr);
      // A frozen branch stays in EX, so its redirect is deferred until memory completes.
      if (w_halt || w_freeze) begin
        pc_stop     = 1'b1;
        if_id_stop  = 1'b1;
        id_ex_stop  = 1'b1;
        ex_mem_stop = 1'b1;
      end else if (ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_stop     = 1'b1;
        if_id_stop  = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (mem_busy) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        S_WAIT: begin
          if (!mem_busy) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WC_W'(TIMEOUT - 1)) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        S_ERR: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state    <= S_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stop && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (if_id_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign err       = r_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
// ctl vector order: {pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop}
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_wr, mem_wr, wb_wr;
  logic        id_re1, id_re2, ex_we, mem_we, wb_we, ex_br_taken, mem_busy;
  logic [1:0]  ex_rf_wesl;
  logic        pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop;
  logic [1:0]  fwd_a, fwd_b;
  logic        err;
  logic [15:0] stall_cnt, flush_cnt;
  logic [5:0]  ctl;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_stall = 16'd0;
  logic [15:0] exp_flush = 16'd0;

  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_LU     = 6'b110010;
  localparam logic [5:0] C_BR     = 6'b001010;
  localparam logic [5:0] C_FREEZE = 6'b110101;

  always #5 clk = ~clk;

  assign ctl = {pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop};

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(16), .WESL_LOAD(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wr(ex_wr), .ex_we(ex_we), .ex_rf_wesl(ex_rf_wesl),
    .mem_wr(mem_wr), .mem_we(mem_we), .wb_wr(wb_wr), .wb_we(wb_we),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_stop(pc_stop), .if_id_stop(if_id_stop), .if_id_flush(if_id_flush),
    .id_ex_stop(id_ex_stop), .id_ex_flush(id_ex_flush), .ex_mem_stop(ex_mem_stop),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .err(err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clr_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
    ex_wr = 5'd0; ex_we = 1'b0; ex_rf_wesl = 2'b00;
    mem_wr = 5'd0; mem_we = 1'b0; wb_wr = 5'd0; wb_we = 1'b0;
    ex_br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  // Inputs are already driven; check at negedge, clock once, check counters.
  task automatic step(input string tag, input logic [5:0] e_ctl, input logic [1:0] e_fa,
                      input logic [1:0] e_fb, input logic e_err);
    @(negedge clk);
    check_eq({tag, "/ctl"}, 32'(ctl), 32'(e_ctl));
    check_eq({tag, "/fwd_a"}, 32'(fwd_a), 32'(e_fa));
    check_eq({tag, "/fwd_b"}, 32'(fwd_b), 32'(e_fb));
    check_eq({tag, "/err"}, 32'(err), 32'(e_err));
    if (e_ctl[5] && exp_stall != 16'hFFFF) exp_stall++;
    if (e_ctl[3] && exp_flush != 16'hFFFF) exp_flush++;
    @(posedge clk);
    #1;
    check_eq({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check_eq({tag, "/flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    ex_wr = 5'd5; ex_we = 1'b1; ex_rf_wesl = 2'b01; id_rs1 = 5'd5; id_re1 = 1'b1;
    mem_wr = 5'd5; mem_we = 1'b1; mem_busy = 1'b1; ex_br_taken = 1'b1;
    #11;
    check_eq("rst/ctl", 32'(ctl), 32'(C_NONE));
    check_eq("rst/fwd_a", 32'(fwd_a), 32'd0);
    check_eq("rst/err", 32'(err), 32'd0);
    check_eq("rst/stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst/flush_cnt", 32'(flush_cnt), 32'd0);
    clr_in();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // load-use on rs1, then the load has moved to MEM and forwards from there
    clr_in(); ex_wr = 5'd5; ex_we = 1'b1; ex_rf_wesl = 2'b01; id_rs1 = 5'd5; id_re1 = 1'b1;
    id_rs2 = 5'd3; id_re2 = 1'b1; wb_wr = 5'd3; wb_we = 1'b1;
    step("lu_rs1", C_LU, 2'd0, 2'd3, 1'b0);
    clr_in(); mem_wr = 5'd5; mem_we = 1'b1; id_rs1 = 5'd5; id_re1 = 1'b1;
    step("lu_after", C_NONE, 2'd2, 2'd0, 1'b0);
    clr_in(); ex_wr = 5'd9; ex_we = 1'b1; ex_rf_wesl = 2'b01; id_rs2 = 5'd9; id_re2 = 1'b1;
    step("lu_rs2", C_LU, 2'd0, 2'd0, 1'b0);
    id_re2 = 1'b0;
    step("lu_re0", C_NONE, 2'd0, 2'd0, 1'b0);

    // branch beats load-use
    clr_in(); ex_wr = 5'd5; ex_we = 1'b1; ex_rf_wesl = 2'b01; id_rs1 = 5'd5; id_re1 = 1'b1;
    ex_br_taken = 1'b1;
    step("br_lu", C_BR, 2'd0, 2'd0, 1'b0);

    // freeze beats branch for 3 busy cycles, then the branch squashes
    clr_in(); mem_busy = 1'b1; ex_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) step("busy_br", C_FREEZE, 2'd0, 2'd0, 1'b0);
    mem_busy = 1'b0;
    step("br_release", C_BR, 2'd0, 2'd0, 1'b0);

    // x0 is never forwarded and never stalls
    clr_in(); ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1; id_re1 = 1'b1; id_re2 = 1'b1;
    step("x0_alu", C_NONE, 2'd0, 2'd0, 1'b0);
    ex_rf_wesl = 2'b01;
    step("x0_load", C_NONE, 2'd0, 2'd0, 1'b0);

    // forwarding priority
    clr_in(); ex_wr = 5'd7; ex_we = 1'b1; mem_wr = 5'd7; mem_we = 1'b1; wb_wr = 5'd7; wb_we = 1'b1;
    id_rs1 = 5'd7; id_rs2 = 5'd7; id_re1 = 1'b1; id_re2 = 1'b1;
    step("fwd_ex", C_NONE, 2'd1, 2'd1, 1'b0);
    ex_we = 1'b0;
    step("fwd_mem_wb", C_NONE, 2'd2, 2'd2, 1'b0);
    id_re1 = 1'b0;
    step("fwd_re1_0", C_NONE, 2'd0, 2'd2, 1'b0);
    mem_we = 1'b0;
    step("fwd_wb", C_NONE, 2'd0, 2'd3, 1'b0);
    id_re1 = 1'b1; mem_we = 1'b1; ex_we = 1'b1; ex_rf_wesl = 2'b01;
    step("fwd_ld_ex", C_LU, 2'd2, 2'd2, 1'b0);

    // watchdog: 4 busy cycles then ERR, which ignores branch and busy and still forwards
    clr_in(); mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) step("wdog", C_FREEZE, 2'd0, 2'd0, 1'b0);
    clr_in(); ex_br_taken = 1'b1; wb_wr = 5'd4; wb_we = 1'b1; id_rs1 = 5'd4; id_re1 = 1'b1;
    step("err_hold", C_FREEZE, 2'd3, 2'd0, 1'b1);

    // stall counter saturates while ERR keeps pc_stop high
    repeat (65600) @(posedge clk);
    @(negedge clk);
    check_eq("sat/stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
    check_eq("sat/flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    check_eq("sat/ctl", 32'(ctl), 32'(C_FREEZE));

    // asynchronous reset mid-ERR clears everything without a clock edge
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst/ctl", 32'(ctl), 32'(C_NONE));
    check_eq("arst/fwd_a", 32'(fwd_a), 32'd0);
    check_eq("arst/err", 32'(err), 32'd0);
    check_eq("arst/stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("arst/flush_cnt", 32'(flush_cnt), 32'd0);
    #1 rst_n = 1'b1;
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    clr_in(); wb_wr = 5'd4; wb_we = 1'b1; id_rs1 = 5'd4; id_re1 = 1'b1;
    @(posedge clk); #1;
    step("post_rst", C_NONE, 2'd3, 2'd0, 1'b0);
    mem_busy = 1'b1;
    step("post_rst_busy", C_FREEZE, 2'd3, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
